// File: rtl/cpu_control_fsm.sv
// Multicycle control unit for the 8-bit CPU: owns PC, IR and N/Z flags and sequences
// fetch, decode and execute over the register file, ALU and single-port synchronous memory.
module cpu_control_fsm #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       run,
  input  logic       step_mode,
  input  logic       step,
  input  logic [7:0] Data_out,
  input  logic [7:0] dataA,
  input  logic [7:0] dataB,
  input  logic [7:0] ALUout,
  input  logic       N,
  input  logic       Z,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [7:0] ADDR,
  output logic [7:0] Data_in,
  output logic       RFWrite,
  output logic [3:0] regA,
  output logic [3:0] regB,
  output logic [3:0] regW,
  output logic [7:0] dataW,
  output logic [2:0] ALUop,
  output logic [7:0] PC,
  output logic       flagN,
  output logic       flagZ,
  output logic       halted
);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StFwait,
    StDecode,
    StExec,
    StMrd,
    StMwait,
    StMwr,
    StIrd,
    StIwait,
    StBranch,
    StPause,
    StHalt
  } state_e;

  localparam logic [2:0] OpLoad  = 3'b000;
  localparam logic [2:0] OpStore = 3'b001;
  localparam logic [2:0] OpLdi   = 3'b010;
  localparam logic [2:0] OpBz    = 3'b011;
  localparam logic [2:0] OpBnz   = 3'b100;
  localparam logic [2:0] OpBn    = 3'b101;
  localparam logic [2:0] OpHalt  = 3'b111;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       flag_n_q, flag_n_d;
  logic       flag_z_q, flag_z_d;
  logic       mrd_setup_q, mrd_setup_d;
  logic       instr_end;
  logic       taken;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pc_q        <= PC_RESET;
      ir_q        <= 8'h00;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      mrd_setup_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      mrd_setup_q <= mrd_setup_d;
    end
  end

  always_comb begin
    case (ir_q[6:4])
      OpBz:    taken = flag_z_q;
      OpBnz:   taken = ~flag_z_q;
      OpBn:    taken = flag_n_q;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    mrd_setup_d = 1'b0;
    instr_end   = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RFWrite     = 1'b0;
    ADDR        = pc_q;
    dataW       = 8'h00;
    ALUop       = 3'b000;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        MemRead = 1'b1;
        state_d = StFwait;
      end
      StFwait: begin
        ir_d    = Data_out;
        pc_d    = pc_q + 8'd1;
        state_d = StDecode;
      end
      StDecode: begin
        if (ir_q[7]) begin
          state_d = StExec;
        end else begin
          case (ir_q[6:4])
            OpLoad:  state_d = StMrd;
            OpStore: state_d = StMwr;
            OpLdi:   state_d = StIrd;
            OpHalt:  state_d = StHalt;
            default: state_d = StBranch;
          endcase
        end
      end
      StExec: begin
        ALUop     = ir_q[6:4];
        RFWrite   = 1'b1;
        dataW     = ALUout;
        flag_n_d  = N;
        flag_z_d  = Z;
        instr_end = 1'b1;
      end
      StMrd: begin
        // First MRD cycle only presents the address; the read strobe follows a cycle later.
        ADDR = dataB;
        if (!mrd_setup_q) begin
          mrd_setup_d = 1'b1;
        end else begin
          MemRead = 1'b1;
          state_d = StMwait;
        end
      end
      StMwait: begin
        ADDR      = dataB;
        RFWrite   = 1'b1;
        dataW     = Data_out;
        instr_end = 1'b1;
      end
      StMwr: begin
        MemWrite  = 1'b1;
        ADDR      = dataB;
        instr_end = 1'b1;
      end
      StIrd: begin
        MemRead = 1'b1;
        state_d = StIwait;
      end
      StIwait: begin
        RFWrite   = 1'b1;
        dataW     = Data_out;
        pc_d      = pc_q + 8'd1;
        instr_end = 1'b1;
      end
      StBranch: begin
        if (taken) pc_d = dataB;
        instr_end = 1'b1;
      end
      StPause: begin
        if (!run) state_d = StIdle;
        else if (step) state_d = StFetch;
      end
      StHalt: begin
        if (!run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (instr_end) begin
      if (!run) state_d = StIdle;
      else if (step_mode) state_d = StPause;
      else state_d = StFetch;
    end
  end

  assign Data_in = dataA;
  assign regA    = {2'b00, ir_q[3:2]};
  assign regB    = {2'b00, ir_q[1:0]};
  assign regW    = {2'b00, ir_q[3:2]};
  assign PC      = pc_q;
  assign flagN   = flag_n_q;
  assign flagZ   = flag_z_q;
  assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: a behavioural memory/RF/ALU datapath around the DUT, directed
// scenarios, and random programs checked against an instruction-level reference model.
module tb_cpu_control_fsm;

  logic       CLOCK_50, resetn, run, step_mode, step;
  logic [7:0] Data_out, dataA, dataB, ALUout;
  logic       N, Z;
  logic       MemRead, MemWrite, RFWrite, flagN, flagZ, halted;
  logic [7:0] ADDR, Data_in, dataW, PC;
  logic [3:0] regA, regB, regW;
  logic [2:0] ALUop;

  int vectors;
  int miscompares;

  logic [7:0] mem      [256];
  logic [7:0] rf       [16];
  logic [7:0] init_mem [256];
  logic [7:0] init_rf  [16];
  logic       load_en;

  cpu_control_fsm #(.PC_RESET(8'h00)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .run      (run),
    .step_mode(step_mode),
    .step     (step),
    .Data_out (Data_out),
    .dataA    (dataA),
    .dataB    (dataB),
    .ALUout   (ALUout),
    .N        (N),
    .Z        (Z),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ADDR     (ADDR),
    .Data_in  (Data_in),
    .RFWrite  (RFWrite),
    .regA     (regA),
    .regB     (regB),
    .regW     (regW),
    .dataW    (dataW),
    .ALUop    (ALUop),
    .PC       (PC),
    .flagN    (flagN),
    .flagZ    (flagZ),
    .halted   (halted)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Datapath environment: synchronous memory, register file, combinational ALU.
  always @(posedge CLOCK_50) begin
    if (load_en) begin
      mem <= init_mem;
      rf  <= init_rf;
    end else begin
      if (MemWrite) mem[ADDR] <= Data_in;
      if (RFWrite) rf[regW] <= dataW;
    end
    if (MemRead) Data_out <= mem[ADDR];
  end

  assign dataA  = rf[regA];
  assign dataB  = rf[regB];
  assign ALUout = alu_f(ALUop, dataA, dataB);
  assign N      = ALUout[7];
  assign Z      = (ALUout == 8'h00);

  task automatic clear_images();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) init_rf[i] = 8'h00;
  endtask

  // Loads the environment images while the DUT is held in reset; returns on a negedge.
  task automatic do_reset();
    @(negedge CLOCK_50);
    load_en   = 1'b1;
    resetn    = 1'b0;
    run       = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    load_en = 1'b0;
    resetn  = 1'b1;
  endtask

  task automatic test_reset();
    clear_images();
    do_reset();
    vectors++;
    if (PC !== 8'h00 || flagN !== 1'b0 || flagZ !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got PC=%h N=%b Z=%b halted=%b, want 00/0/0/0",
               PC, flagN, flagZ, halted);
    end
    vectors++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0 || RFWrite !== 1'b0 || ALUop !== 3'b000 ||
        ADDR !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_strobes: got MR=%b MW=%b RW=%b op=%h ADDR=%h, want 0/0/0/0/00",
               MemRead, MemWrite, RFWrite, ALUop, ADDR);
    end
    repeat (3) @(negedge CLOCK_50);
    vectors++;
    if (MemRead !== 1'b0 || PC !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_hold: got MR=%b PC=%h, want 0/00", MemRead, PC);
    end
  endtask

  task automatic test_store();
    int wr_cnt;
    clear_images();
    init_mem[0] = 8'h24;  // LDI r1
    init_mem[1] = 8'h05;
    init_mem[2] = 8'h14;  // STORE r1,[r0]
    init_mem[3] = 8'h70;  // HALT
    do_reset();
    run    = 1'b1;
    wr_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLOCK_50);
      if (MemWrite) begin
        wr_cnt++;
        vectors++;
        if (c != 8 || ADDR !== 8'h00 || Data_in !== 8'h05 || PC !== 8'h03) begin
          miscompares++;
          $display("FAIL store_write: got cyc=%0d ADDR=%h Din=%h PC=%h, want 8/00/05/03",
                   c, ADDR, Data_in, PC);
        end
      end
      if (c >= 12) begin
        vectors++;
        if (halted !== 1'b1) begin
          miscompares++;
          $display("FAIL store_halt: got halted=%b at cyc %0d, want 1", halted, c);
        end
      end
    end
    vectors++;
    if (wr_cnt != 1 || mem[0] !== 8'h05) begin
      miscompares++;
      $display("FAIL store_once: got writes=%0d M0=%h, want 1/05", wr_cnt, mem[0]);
    end
    run = 1'b0;
    @(negedge CLOCK_50);
    vectors++;
    if (halted !== 1'b0 || MemRead !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_release: got halted=%b MR=%b, want 0/0", halted, MemRead);
    end
  endtask

  task automatic test_load();
    int rw_cnt, rd_cyc;
    clear_images();
    init_mem[0] = 8'h28;  // LDI r2
    init_mem[1] = 8'h07;
    init_mem[2] = 8'h0E;  // LOAD r3,[r2]
    init_mem[3] = 8'h70;
    init_mem[7] = 8'hA5;
    do_reset();
    run    = 1'b1;
    rw_cnt = 0;
    rd_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLOCK_50);
      if (RFWrite) begin
        rw_cnt++;
        vectors++;
        if (!((c == 4 && regW === 4'd2 && dataW === 8'h07) ||
              (c == 10 && regW === 4'd3 && dataW === 8'hA5))) begin
          miscompares++;
          $display("FAIL load_rfwrite: got cyc=%0d regW=%0d dataW=%h, want 4/2/07 or 10/3/A5",
                   c, regW, dataW);
        end
      end
      if (MemRead && ADDR === 8'h07) rd_cyc = c;
    end
    vectors++;
    if (rw_cnt != 2 || rd_cyc < 8 || rd_cyc > 9) begin
      miscompares++;
      $display("FAIL load_read: got rfwrites=%0d read_cyc=%0d, want 2 and 8..9", rw_cnt, rd_cyc);
    end
    vectors++;
    if (MemRead !== 1'b1 || ADDR !== 8'h03 || rf[3] !== 8'hA5) begin
      miscompares++;
      $display("FAIL load_6cyc: got MR=%b ADDR=%h r3=%h, want 1/03/A5", MemRead, ADDR, rf[3]);
    end
  endtask

  task automatic test_alu();
    clear_images();
    init_rf[1]  = 8'h05;
    init_rf[2]  = 8'h05;
    init_mem[0] = 8'h96;  // SUB r1,r2
    init_mem[1] = 8'h70;
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLOCK_50);
      vectors++;
      if (c == 3) begin
        if (ALUop !== 3'b001 || regA !== 4'd1 || regB !== 4'd2 || RFWrite !== 1'b1 ||
            dataW !== 8'h00 || flagZ !== 1'b0) begin
          miscompares++;
          $display("FAIL alu_exec: got op=%h A=%0d B=%0d RW=%b W=%h Z=%b, want 1/1/2/1/00/0",
                   ALUop, regA, regB, RFWrite, dataW, flagZ);
        end
      end else if (ALUop !== 3'b000) begin
        miscompares++;
        $display("FAIL alu_op_idle: got op=%h at cyc %0d, want 0", ALUop, c);
      end
      if (c >= 4) begin
        vectors++;
        if (flagZ !== 1'b1 || flagN !== 1'b0) begin
          miscompares++;
          $display("FAIL alu_flags: got Z=%b N=%b at cyc %0d, want 1/0", flagZ, flagN, c);
        end
      end
    end
    vectors++;
    if (halted !== 1'b1 || rf[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL alu_result: got halted=%b r1=%h, want 1/00", halted, rf[1]);
    end
  endtask

  task automatic test_branch();
    logic [7:0] ir0, ir1, exp;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       begin ir0 = 8'hC0; ir1 = 8'h31; exp = 8'h40; end  // Z=1, BZ taken
        1:       begin ir0 = 8'hAA; ir1 = 8'h31; exp = 8'h02; end  // Z=0, BZ not taken
        2:       begin ir0 = 8'hAA; ir1 = 8'h41; exp = 8'h40; end  // Z=0, BNZ taken
        default: begin ir0 = 8'hBF; ir1 = 8'h51; exp = 8'h40; end  // N=1, BN taken
      endcase
      clear_images();
      init_rf[1]     = 8'h40;
      init_rf[2]     = 8'h03;
      init_rf[3]     = 8'h80;
      init_mem[0]    = ir0;
      init_mem[1]    = ir1;
      init_mem[2]    = 8'h70;
      init_mem[8'h40] = 8'h70;
      do_reset();
      run = 1'b1;
      repeat (9) @(negedge CLOCK_50);
      vectors++;
      if (MemRead !== 1'b1 || ADDR !== exp || PC !== exp) begin
        miscompares++;
        $display("FAIL branch_%0d: got MR=%b ADDR=%h PC=%h, want 1/%h/%h",
                 k, MemRead, ADDR, PC, exp, exp);
      end
    end
  endtask

  task automatic test_wrap_step();
    clear_images();
    init_rf[1]      = 8'hFF;
    init_mem[0]     = 8'h61;  // JMP r1
    init_mem[8'hFF] = 8'h28;  // LDI r2 at the top of memory
    init_mem[1]     = 8'h70;
    do_reset();
    run       = 1'b1;
    step_mode = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLOCK_50);
      if ((c >= 4 && c <= 6) || c == 12 || c == 13) begin
        vectors++;
        if (MemRead !== 1'b0 || PC !== ((c < 7) ? 8'hFF : 8'h01)) begin
          miscompares++;
          $display("FAIL pause_%0d: got MR=%b PC=%h, want 0/%h",
                   c, MemRead, PC, (c < 7) ? 8'hFF : 8'h01);
        end
      end
      if (c == 7 || c == 10 || c == 14) begin
        vectors++;
        if (MemRead !== 1'b1 || ADDR !== ((c == 7) ? 8'hFF : (c == 10) ? 8'h00 : 8'h01)) begin
          miscompares++;
          $display("FAIL wrap_read_%0d: got MR=%b ADDR=%h", c, MemRead, ADDR);
        end
      end
      if (c == 11) begin
        vectors++;
        if (RFWrite !== 1'b1 || regW !== 4'd2 || dataW !== 8'h61) begin
          miscompares++;
          $display("FAIL wrap_imm: got RW=%b regW=%0d dataW=%h, want 1/2/61",
                   RFWrite, regW, dataW);
        end
      end
      step = (c == 6 || c == 13);
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_halt: got halted=%b, want 1", halted);
    end
    step_mode = 1'b0;
    run       = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    clear_images();
    init_rf[0]  = 8'h20;
    init_rf[1]  = 8'h99;
    init_mem[0] = 8'h14;  // STORE r1,[r0]
    do_reset();
    run = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    vectors++;
    if (MemWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL mwr_reach: got MW=%b, want 1", MemWrite);
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (MemWrite !== 1'b0 || MemRead !== 1'b0 || RFWrite !== 1'b0 || PC !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got MW=%b MR=%b RW=%b PC=%h, want 0/0/0/00",
               MemWrite, MemRead, RFWrite, PC);
    end
    run = 1'b0;
    @(negedge CLOCK_50);
    vectors++;
    if (mem[8'h20] !== 8'h00) begin
      miscompares++;
      $display("FAIL no_partial_write: got M20=%h, want 00", mem[8'h20]);
    end
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    vectors++;
    if (MemRead !== 1'b0 || halted !== 1'b0 || PC !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_idle: got MR=%b halted=%b PC=%h, want 0/0/00", MemRead, halted, PC);
    end
  endtask

  // Random programs against an instruction-level model: each instruction's effect on
  // PC, flags, registers and memory, its cycle count and its bus strobes.
  task automatic test_random();
    logic [7:0] m_mem [256];
    logic [7:0] m_reg [4];
    logic [7:0] m_pc, ir, a, b, res, rd_addr, exp_pc;
    logic [1:0] rx, ry;
    logic [2:0] op;
    logic       m_n, m_z, done;
    int         cyc, kind, reads, exp_reads, bad;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) begin
        init_mem[i] = 8'($urandom);
        m_mem[i]    = init_mem[i];
      end
      for (int i = 0; i < 16; i++) init_rf[i] = (i < 4) ? 8'($urandom) : 8'h00;
      for (int i = 0; i < 4; i++) m_reg[i] = init_rf[i];
      do_reset();
      run  = 1'b1;
      m_pc = 8'h00;
      m_n  = 1'b0;
      m_z  = 1'b0;
      done = 1'b0;
      @(negedge CLOCK_50);
      for (int n = 0; n < 60 && !done; n++) begin
        vectors++;
        if (MemRead !== 1'b1 || ADDR !== m_pc) begin
          miscompares++;
          $display("FAIL rnd_fetch: got MR=%b ADDR=%h, want 1/%h", MemRead, ADDR, m_pc);
        end
        ir        = m_mem[m_pc];
        rx        = ir[3:2];
        ry        = ir[1:0];
        op        = ir[6:4];
        a         = m_reg[rx];
        b         = m_reg[ry];
        exp_pc    = m_pc + 8'd1;
        exp_reads = 1;
        rd_addr   = 8'h00;
        res       = 8'h00;
        if (ir[7]) begin
          kind = 0; cyc = 4; res = alu_f(op, a, b);
        end else begin
          case (op)
            3'd0: begin kind = 1; cyc = 6; rd_addr = b; res = m_mem[b]; exp_reads = 2; end
            3'd1: begin kind = 2; cyc = 4; end
            3'd2: begin
              kind = 3; cyc = 5; rd_addr = exp_pc; res = m_mem[exp_pc]; exp_reads = 2;
              exp_pc = exp_pc + 8'd1;
            end
            3'd7: begin kind = 5; cyc = 3; end
            default: begin
              kind = 4; cyc = 4;
              if ((op == 3'd3 && m_z) || (op == 3'd4 && !m_z) || (op == 3'd5 && m_n) ||
                  op == 3'd6) exp_pc = b;
            end
          endcase
        end
        reads = 0;
        for (int c = 0; c < cyc; c++) begin
          if (c > 0) @(negedge CLOCK_50);
          if (MemRead) reads++;
          vectors++;
          if (int'(MemRead) + int'(MemWrite) + int'(RFWrite) > 1 ||
              (c != cyc - 1 && (MemWrite || RFWrite)) ||
              (MemRead && c > 0 && ADDR !== rd_addr) ||
              ALUop !== ((kind == 0 && c == cyc - 1) ? op : 3'b000)) begin
            miscompares++;
            $display("FAIL rnd_bus: ir=%h cyc=%0d got MR=%b MW=%b RW=%b ADDR=%h op=%h",
                     ir, c, MemRead, MemWrite, RFWrite, ADDR, ALUop);
          end
          if (c == cyc - 1 && (kind == 0 || kind == 1 || kind == 3)) begin
            vectors++;
            if (RFWrite !== 1'b1 || regW !== {2'b00, rx} || dataW !== res) begin
              miscompares++;
              $display("FAIL rnd_rfw: ir=%h got RW=%b regW=%0d dataW=%h, want 1/%0d/%h",
                       ir, RFWrite, regW, dataW, rx, res);
            end
          end
          if (c == cyc - 1 && kind == 2) begin
            vectors++;
            if (MemWrite !== 1'b1 || ADDR !== b || Data_in !== a) begin
              miscompares++;
              $display("FAIL rnd_store: ir=%h got MW=%b ADDR=%h Din=%h, want 1/%h/%h",
                       ir, MemWrite, ADDR, Data_in, b, a);
            end
          end
        end
        @(negedge CLOCK_50);
        case (kind)
          0: begin m_reg[rx] = res; m_n = res[7]; m_z = (res == 8'h00); end
          1, 3: m_reg[rx] = res;
          2: m_mem[b] = a;
          default: ;
        endcase
        m_pc = exp_pc;
        if (kind == 5) begin
          vectors++;
          if (halted !== 1'b1 || MemRead !== 1'b0 || PC !== m_pc) begin
            miscompares++;
            $display("FAIL rnd_halt: got halted=%b MR=%b PC=%h, want 1/0/%h",
                     halted, MemRead, PC, m_pc);
          end
          run = 1'b0;
          @(negedge CLOCK_50);
          vectors++;
          if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_unhalt: got halted=%b, want 0", halted);
          end
          done = 1'b1;
        end else begin
          bad = 0;
          for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
          for (int i = 0; i < 4; i++) if (rf[i] !== m_reg[i]) bad++;
          vectors++;
          if (bad != 0 || reads != exp_reads || PC !== m_pc || flagN !== m_n ||
              flagZ !== m_z) begin
            miscompares++;
            $display("FAIL rnd_state: ir=%h got PC=%h N=%b Z=%b reads=%0d diffs=%0d, want %h/%b/%b/%0d/0",
                     ir, PC, flagN, flagZ, reads, bad, m_pc, m_n, m_z, exp_reads);
          end
        end
      end
      run = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b1;
    run         = 1'b0;
    step_mode   = 1'b0;
    step        = 1'b0;
    load_en     = 1'b0;
    test_reset();
    test_store();
    test_load();
    test_alu();
    test_branch();
    test_wrap_step();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
